// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states and the
// bit positions of the captured flags in RES_FLAGS.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        READ   = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

    localparam int FLAG_OF = 3;
    localparam int FLAG_SF = 2;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_CF = 0;

endpackage

// File: rtl/alu_op_sequencer.sv
// Single-command front-end for ALU_SUB: loads A and B over the shared DATA bus,
// fires execute, reads the result back and hands it downstream.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [3:0]       CMD_OPCODE,
    input  logic [WIDTH-1:0] CMD_A,
    input  logic [WIDTH-1:0] CMD_B,
    output logic [WIDTH-1:0] DATA,
    output logic             A_EN,
    output logic             B_EN,
    output logic             ALU_EN,
    output logic             ALU_OE,
    output logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] ALU_DATA,
    input  logic             OF,
    input  logic             SF,
    input  logic             ZF,
    input  logic             CF,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [WIDTH-1:0] RES_DATA,
    output logic [3:0]       RES_FLAGS,
    output logic             BUSY,
    output logic [CNT_W-1:0] OP_COUNT
);

    seq_state_t       state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            RES_DATA  <= '0;
            RES_FLAGS <= '0;
            OP_COUNT  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID) begin
                        op_q  <= CMD_OPCODE;
                        a_q   <= CMD_A;
                        b_q   <= CMD_B;
                        state <= LOAD_A;
                    end
                end
                LOAD_A: state <= LOAD_B;
                LOAD_B: state <= EXEC;
                EXEC:   state <= READ;
                READ: begin
                    // ALU_OE is up for this whole cycle, so ALU_DATA is valid at the closing edge
                    RES_DATA           <= ALU_DATA;
                    RES_FLAGS[FLAG_OF] <= OF;
                    RES_FLAGS[FLAG_SF] <= SF;
                    RES_FLAGS[FLAG_ZF] <= ZF;
                    RES_FLAGS[FLAG_CF] <= CF;
                    state              <= DONE;
                end
                DONE: begin
                    if (RES_READY) begin
                        OP_COUNT <= OP_COUNT + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pure decode of the state register: reset forces IDLE, so strobes drop with RST.
    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign A_EN      = (state == LOAD_A);
    assign B_EN      = (state == LOAD_B);
    assign ALU_EN    = (state == EXEC);
    assign ALU_OE    = (state == READ);
    assign RES_VALID = (state == DONE);

    assign DATA   = (state == LOAD_A) ? a_q :
                    (state == LOAD_B) ? b_q : '0;
    assign OPCODE = (state == LOAD_A || state == LOAD_B ||
                     state == EXEC   || state == READ) ? op_q : 4'h0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Sequencer paired with a behavioural ALU_SUB; a cycle-count model predicts every
// output and directed literal checks pin latency, flag values and reset behaviour.
module tb_alu_op_sequencer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         CMD_VALID;
    logic         CMD_READY;
    logic [3:0]   CMD_OPCODE;
    logic [W-1:0] CMD_A, CMD_B;
    logic [W-1:0] DATA;
    logic         A_EN, B_EN, ALU_EN, ALU_OE;
    logic [3:0]   OPCODE;
    logic [W-1:0] ALU_DATA;
    logic         OF, SF, ZF, CF;
    logic         RES_VALID, RES_READY;
    logic [W-1:0] RES_DATA;
    logic [3:0]   RES_FLAGS;
    logic         BUSY;
    logic [15:0]  OP_COUNT;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    alu_op_sequencer #(.WIDTH(W), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OPCODE(CMD_OPCODE), .CMD_A(CMD_A), .CMD_B(CMD_B), .DATA(DATA),
        .A_EN(A_EN), .B_EN(B_EN), .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .OPCODE(OPCODE),
        .ALU_DATA(ALU_DATA), .OF(OF), .SF(SF), .ZF(ZF), .CF(CF),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
        .RES_FLAGS(RES_FLAGS), .BUSY(BUSY), .OP_COUNT(OP_COUNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Opcodes understood by the ALU stand-in: 0 add, 1 subtract, others pass A.
    // Returns {OF,SF,ZF,CF, result}.
    function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic       of;
        case (op)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; of = (a[7] == b[7]) && (s[7] != a[7]); end
            4'h1: begin s = {1'b0, a} - {1'b0, b}; of = (a[7] != b[7]) && (s[7] != a[7]); end
            default: begin s = {1'b0, a}; of = 1'b0; end
        endcase
        return {of, s[7], (s[7:0] == 8'h00), s[8], s[7:0]};
    endfunction

    // ALU_SUB stand-in: registered operands, result registered on ALU_EN, bus driven on ALU_OE.
    logic [7:0] alu_a = '0, alu_b = '0, alu_r = '0;
    logic [3:0] alu_f = '0;
    always @(posedge CLK) begin
        if (A_EN) alu_a <= DATA;
        if (B_EN) alu_b <= DATA;
        if (ALU_EN) {alu_f, alu_r} <= alu_ref(OPCODE, alu_a, alu_b);
    end
    assign ALU_DATA      = ALU_OE ? alu_r : 8'h00;
    assign {OF, SF, ZF, CF} = alu_f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_step counts cycles since accept (0 = waiting for a command, 5 = result held).
    int         m_step  = 0;
    logic [3:0] m_op    = '0;
    logic [7:0] m_a     = '0, m_b = '0, m_res = '0;
    logic [3:0] m_flags = '0;
    logic [15:0] m_count = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_step = 0; m_op = '0; m_a = '0; m_b = '0;
            m_res = '0; m_flags = '0; m_count = '0;
        end else if (m_step == 0) begin
            if (CMD_VALID) begin
                m_op = CMD_OPCODE; m_a = CMD_A; m_b = CMD_B; m_step = 1;
            end
        end else if (m_step < 5) begin
            if (m_step == 4) {m_flags, m_res} = alu_ref(m_op, m_a, m_b);
            m_step++;
        end else if (RES_READY) begin
            m_count++;
            m_step = 0;
        end
    end

    always @(negedge CLK) begin
        chk("cmd_ready", 32'(CMD_READY), 32'(m_step == 0));
        chk("busy",      32'(BUSY),      32'(m_step != 0));
        chk("a_en",      32'(A_EN),      32'(m_step == 1));
        chk("b_en",      32'(B_EN),      32'(m_step == 2));
        chk("alu_en",    32'(ALU_EN),    32'(m_step == 3));
        chk("alu_oe",    32'(ALU_OE),    32'(m_step == 4));
        chk("res_valid", 32'(RES_VALID), 32'(m_step == 5));
        chk("data",      32'(DATA),      32'((m_step == 1) ? m_a : (m_step == 2) ? m_b : 8'h00));
        chk("opcode",    32'(OPCODE),    32'((m_step >= 1 && m_step <= 4) ? m_op : 4'h0));
        chk("res_data",  32'(RES_DATA),  32'(m_res));
        chk("res_flags", 32'(RES_FLAGS), 32'(m_flags));
        chk("op_count",  32'(OP_COUNT),  32'(m_count));
        chk("strobe_onehot", 32'($onehot0({A_EN, B_EN, ALU_EN, ALU_OE})), 32'(1));
    end

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        CMD_VALID = 1'b1; CMD_OPCODE = op; CMD_A = a; CMD_B = b;
        for (int i = 0; i < 50; i++) begin
            if (CMD_READY) begin
                @(negedge CLK);
                CMD_VALID = 1'b0;
                return;
            end
            @(negedge CLK);
        end
        n_vec++; n_err++;
        $display("FAIL send_timeout: CMD_READY stayed 0 for 50 cycles");
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (RES_VALID) return;
            @(negedge CLK);
        end
        n_vec++; n_err++;
        $display("FAIL res_valid_timeout: RES_VALID stayed 0 for 20 cycles");
    endtask

    int acc_cyc [3];

    initial begin
        RST = 1'b1; CMD_VALID = 1'b0; CMD_OPCODE = '0; CMD_A = '0; CMD_B = '0; RES_READY = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_cmd_ready", 32'(CMD_READY), 32'(1));
        chk("rst_op_count",  32'(OP_COUNT),  32'(0));
        RST = 1'b0;
        @(negedge CLK);

        // Asynchronous reset in the middle of LOAD_B
        send(4'h0, 8'h11, 8'h22);
        @(negedge CLK);
        chk("pre_rst_b_en", 32'(B_EN), 32'(1));
        #3 RST = 1'b1;
        #1;
        chk("arst_b_en",      32'(B_EN),      32'(0));
        chk("arst_data",      32'(DATA),      32'(0));
        chk("arst_cmd_ready", 32'(CMD_READY), 32'(1));
        chk("arst_res_valid", 32'(RES_VALID), 32'(0));
        chk("arst_op_count",  32'(OP_COUNT),  32'(0));
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Single add: literal strobe sequence and latency
        send(4'h0, 8'h25, 8'h1A);
        chk("add_la_a_en", 32'(A_EN), 32'(1));
        chk("add_la_data", 32'(DATA), 32'(8'h25));
        @(negedge CLK);
        chk("add_lb_b_en", 32'(B_EN), 32'(1));
        chk("add_lb_data", 32'(DATA), 32'(8'h1A));
        @(negedge CLK);
        chk("add_ex_alu_en", 32'(ALU_EN), 32'(1));
        @(negedge CLK);
        chk("add_rd_alu_oe", 32'(ALU_OE), 32'(1));
        @(negedge CLK);
        chk("add_valid", 32'(RES_VALID), 32'(1));
        chk("add_data",  32'(RES_DATA),  32'(8'h3F));
        chk("add_flags", 32'(RES_FLAGS), 32'(4'b0000));
        @(negedge CLK);
        chk("add_count", 32'(OP_COUNT),  32'(1));

        // Signed overflow into the sign bit
        send(4'h0, 8'h7F, 8'h01);
        wait_valid();
        chk("ovf_data",  32'(RES_DATA),  32'(8'h80));
        chk("ovf_flags", 32'(RES_FLAGS), 32'(4'b1100));
        @(negedge CLK);

        // Carry out with zero result
        send(4'h0, 8'hFF, 8'h01);
        wait_valid();
        chk("carry_data",  32'(RES_DATA),  32'(8'h00));
        chk("carry_flags", 32'(RES_FLAGS), 32'(4'b0011));
        @(negedge CLK);

        // Backpressure: result held, new commands ignored
        RES_READY = 1'b0;
        send(4'h1, 8'h10, 8'h10);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            CMD_VALID = 1'b1; CMD_OPCODE = 4'h0; CMD_A = 8'hAA; CMD_B = 8'h55;
            chk("bp_data",      32'(RES_DATA),  32'(8'h00));
            chk("bp_flags",     32'(RES_FLAGS), 32'(4'b0010));
            chk("bp_cmd_ready", 32'(CMD_READY), 32'(0));
            chk("bp_busy",      32'(BUSY),      32'(1));
            @(negedge CLK);
        end
        CMD_VALID = 1'b0;
        RES_READY = 1'b1;
        @(negedge CLK);
        chk("bp_release_idle",  32'(CMD_READY), 32'(1));
        chk("bp_release_valid", 32'(RES_VALID), 32'(0));
        chk("bp_release_count", 32'(OP_COUNT),  32'(4));

        // Back-to-back with CMD_VALID held high
        for (int k = 0; k < 3; k++) begin
            CMD_VALID = 1'b1; CMD_OPCODE = 4'h1; CMD_A = 8'(8'h40 + 8'(k)); CMD_B = 8'h05;
            acc_cyc[k] = -1;
            for (int i = 0; i < 20 && acc_cyc[k] < 0; i++) begin
                if (CMD_READY) acc_cyc[k] = cyc;
                @(negedge CLK);
            end
        end
        CMD_VALID = 1'b0;
        chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(6));
        chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(6));
        wait_valid();
        chk("b2b_last_data", 32'(RES_DATA), 32'(8'h3D));
        @(negedge CLK);
        chk("b2b_count", 32'(OP_COUNT), 32'(7));

        // Reset while in EXEC: sequence aborted, nothing delivered
        send(4'h0, 8'h01, 8'h02);
        @(negedge CLK);
        @(negedge CLK);
        chk("abort_pre_alu_en", 32'(ALU_EN), 32'(1));
        #2 RST = 1'b1;
        #1;
        chk("abort_alu_en",    32'(ALU_EN),    32'(0));
        chk("abort_op_count",  32'(OP_COUNT),  32'(0));
        chk("abort_cmd_ready", 32'(CMD_READY), 32'(1));
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("abort_no_valid", 32'(RES_VALID), 32'(0));
        end
        chk("abort_count_end", 32'(OP_COUNT), 32'(0));

        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
